scc_mem_arbiter: RTL and testbench

SCC_MEM_ARBITER -- requirements
Module: scc_mem_arbiter

---
 rtl/scc_pkg.sv | 7 +
 rtl/scc_rr_arbiter.sv | 20 ++
 rtl/scc_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_scc_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// scc_pkg: shared FSM state type and default sizing for the memory arbiter.
package scc_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;
endpackage

// File: rtl/scc_rr_arbiter.sv
// scc_rr_arbiter: one-hot grant of the first request at or after the pointer (pointer forced to 0 in fixed mode).
module scc_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_rr,
    output logic [N-1:0]  o_gnt
);
    logic [PW-1:0] w_sh;
    logic [N-1:0]  w_rot;
    logic [N-1:0]  w_pick;

    assign w_sh   = i_rr ? i_ptr : '0;
    // rotate so the pointer sits at bit 0, take lowest set bit, rotate back
    assign w_rot  = N'({i_req, i_req} >> w_sh);
    assign w_pick = w_rot & (-w_rot);
    assign o_gnt  = N'(({w_pick, w_pick} << w_sh) >> N);
endmodule

// File: rtl/scc_mem_arbiter.sv
// scc_mem_arbiter: single-outstanding memory arbiter, IDLE -> ACCESS -> RESP.
// Define SCC_ARB_TIMEOUT_EN to compile in the ACCESS watchdog (TIMEOUT_CYC).
module scc_mem_arbiter
    import scc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = 2,
    parameter int RR_EN  = 0
`ifdef SCC_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t              r_state, w_next;
    logic [PW-1:0]       r_ptr, w_nptr;
    logic [NUM_CH-1:0]   r_gnt, w_gnt;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_wdata, w_wdata, r_rdata;
    logic                r_write, w_write, w_acc, w_done, w_tmo;

    scc_rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .i_rr  (RR_EN != 0),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_write = 1'b0;
        w_nptr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) begin
                w_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_write = req_write[i];
                w_nptr  = PW'((i + 1) % NUM_CH);
            end
        end
    end

    assign w_acc  = (r_state == S_IDLE) && |req_valid;
    assign w_done = (r_state == S_ACCESS) && mem_ready;

`ifdef SCC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign w_tmo = (r_state == S_ACCESS) && !mem_ready && (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == S_ACCESS) ? r_cnt + CW'(1) : '0;
            if (w_done || w_tmo)
                r_err <= w_tmo;
        end
    end

    assign rsp_err = r_err;
`else
    assign w_tmo   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_acc ? S_ACCESS : S_IDLE;
            S_ACCESS: w_next = (w_done || w_tmo) ? S_RESP : S_ACCESS;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_gnt   <= w_gnt;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_write <= w_write;
                if (RR_EN != 0)
                    r_ptr <= w_nptr;
            end
            // writes and timeouts return zero data
            if (w_done || w_tmo)
                r_rdata <= (w_done && !r_write) ? mem_rdata : '0;
        end
    end

    assign req_ready = (r_state == S_IDLE && !reset) ? w_gnt : '0;
    assign mem_read  = (r_state == S_ACCESS) && !r_write;
    assign mem_write = (r_state == S_ACCESS) && r_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_valid = (r_state == S_RESP) ? r_gnt : '0;
    assign rsp_rdata = r_rdata;
endmodule

// File: tb/tb_scc_mem_arbiter.sv
// tb_scc_mem_arbiter: fixed-priority and round-robin instances driven in lockstep, checked per transaction.
module tb_scc_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [DW-1:0]   mem_rdata = '0;
    logic            mem_ready = 1'b0;

    logic [N-1:0]  rdy [2];
    logic [N-1:0]  rv  [2];
    logic [DW-1:0] rd  [2];
    logic [DW-1:0] mwd [2];
    logic [AW-1:0] ma  [2];
    logic          er  [2];
    logic          mr  [2];
    logic          mw  [2];

    int            vectors = 0;
    int            miscompares = 0;
    int            mp = 0;
    logic [DW-1:0] lr [2];

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  wr;
        logic [31:0] a0, a1, d0, d1;
        int          k;
        logic [31:0] r;
        int          gf, gr;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    scc_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CH(N), .RR_EN(0)
`ifdef SCC_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(4)
`endif
    ) u_fix (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]),
        .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_read(mr[0]), .mem_write(mw[0]),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    scc_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CH(N), .RR_EN(1)
`ifdef SCC_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(4)
`endif
    ) u_rr (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]),
        .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_read(mr[1]), .mem_write(mw[1]),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s [%s]: got %h expected %h at %0t", name, d ? "rr" : "fix", act, exp, $time);
        end
    endtask

    function automatic int gfix(input logic [1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic int grr(input logic [1:0] v, input int p);
        for (int j = 0; j < N; j++)
            if (v[(p + j) % N]) return (p + j) % N;
        return -1;
    endfunction

    task automatic txn(input logic [1:0] v, input logic [1:0] wr, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input int k, input logic [31:0] r,
                       input int gf, input int gr);
        int g [2];
        logic [31:0] e;
        g[0] = gf;
        g[1] = gr;
        @(posedge clk); #2;
        req_valid = v; req_write = wr; req_addr = {a1, a0}; req_wdata = {d1, d0};
        mem_ready = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("accept_ready", d, 32'(rdy[d]), 32'(1) << g[d]);
            chk("idle_strobes", d, {30'd0, mr[d], mw[d]}, 32'd0);
            chk("idle_rsp", d, 32'(rv[d]), 32'd0);
            chk("rdata_hold", d, rd[d], lr[d]);
        end
        for (int c = 1; c <= k; c++) begin
            @(posedge clk); #2;
            mem_ready = (c == k); mem_rdata = r;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("mem_read", d, 32'(mr[d]), 32'(!wr[g[d]]));
                chk("mem_write", d, 32'(mw[d]), 32'(wr[g[d]]));
                chk("mem_addr", d, ma[d], g[d] ? a1 : a0);
                chk("mem_wdata", d, mwd[d], g[d] ? d1 : d0);
                chk("busy_ready", d, 32'(rdy[d]), 32'd0);
                chk("busy_rsp", d, 32'(rv[d]), 32'd0);
                chk("rdata_hold", d, rd[d], lr[d]);
            end
        end
        @(posedge clk); #2;
        mem_ready = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e = wr[g[d]] ? 32'd0 : r;
            chk("rsp_valid", d, 32'(rv[d]), 32'(1) << g[d]);
            chk("rsp_rdata", d, rd[d], e);
            chk("rsp_err", d, 32'(er[d]), 32'd0);
            chk("resp_strobes", d, {30'd0, mr[d], mw[d]}, 32'd0);
            chk("resp_ready", d, 32'(rdy[d]), 32'd0);
            lr[d] = e;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        lr[0] = '0;
        lr[1] = '0;
        tbl[0] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h1,  32'h2,  3, 32'hDEADBEEF, 0, 0};
        tbl[1] = '{2'b11, 2'b10, 32'h104, 32'h20,  32'h3,  32'h55, 2, 32'h12345678, 0, 1};
        tbl[2] = '{2'b11, 2'b00, 32'h108, 32'h24,  32'h4,  32'h5,  1, 32'hA5A5A5A5, 0, 0};
        tbl[3] = '{2'b11, 2'b11, 32'h10C, 32'h28,  32'h77, 32'h99, 4, 32'hFFFFFFFF, 0, 1};
        tbl[4] = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0,  32'h0,  3, 32'hDEADBEEF, 0, 0};
        tbl[5] = '{2'b10, 2'b10, 32'h0,   32'h20,  32'h0,  32'h55, 2, 32'hCAFEF00D, 1, 1};
        tbl[6] = '{2'b10, 2'b00, 32'h0,   32'h30,  32'h0,  32'h0,  1, 32'h0BADC0DE, 1, 1};
        tbl[7] = '{2'b11, 2'b00, 32'h40,  32'h44,  32'h0,  32'h0,  2, 32'h13579BDF, 0, 0};

        @(posedge clk); #2;
        req_valid = 2'b11;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", d, 32'(rdy[d]), 32'd0);
            chk("reset_rsp", d, {29'd0, rv[d], er[d]}, 32'd0);
            chk("reset_strobes", d, {30'd0, mr[d], mw[d]}, 32'd0);
            chk("reset_addr", d, ma[d], 32'd0);
            chk("reset_wdata", d, mwd[d], 32'd0);
            chk("reset_rdata", d, rd[d], 32'd0);
        end
        @(posedge clk); #2;
        reset = 1'b0; req_valid = '0;

        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].v, tbl[i].wr, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].k, tbl[i].r, tbl[i].gf, tbl[i].gr);
            mp = (tbl[i].gr + 1) % N;
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0] v;
            int gr;
            v  = 2'($urandom_range(1, 3));
            gr = grr(v, mp);
            txn(v, 2'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom_range(1, 4), $urandom, gfix(v), gr);
            mp = (gr + 1) % N;
        end

        // reset during ACCESS: strobes drop, no response, pointer back to 0
        @(posedge clk); #2;
        req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h300}; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_seq_accept", 1, 32'(rdy[1]), 32'd1);
        @(posedge clk); #2;
        req_valid = '0;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk("rst_seq_access", d, 32'(mr[d]), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            reset = 1'b0; mem_ready = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_strobes", d, {30'd0, mr[d], mw[d]}, 32'd0);
                chk("rst_no_rsp", d, 32'(rv[d]), 32'd0);
                chk("rst_addr", d, ma[d], 32'd0);
                chk("rst_rdata", d, rd[d], 32'd0);
            end
        end
        lr[0] = '0;
        lr[1] = '0;
        mp = 0;
        txn(2'b11, 2'b00, 32'h50, 32'h54, 32'h0, 32'h0, 2, 32'h600DF00D, gfix(2'b11), grr(2'b11, mp));
        mp = (grr(2'b11, mp) + 1) % N;

`ifdef SCC_ARB_TIMEOUT_EN
        @(posedge clk); #2;
        req_valid = 2'b01; req_write = 2'b00; mem_ready = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk("tmo_accept", d, 32'(rdy[d]), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #2;
            req_valid = '0;
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk("tmo_strobe", d, 32'(mr[d]), 32'd1);
        end
        @(posedge clk); #2;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("tmo_rsp_valid", d, 32'(rv[d]), 32'd1);
            chk("tmo_rsp_err", d, 32'(er[d]), 32'd1);
            chk("tmo_rdata", d, rd[d], 32'd0);
            chk("tmo_strobes", d, {30'd0, mr[d], mw[d]}, 32'd0);
        end
`endif

        @(posedge clk); #2;
        req_valid = '0; mem_ready = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("final_idle_rsp", d, 32'(rv[d]), 32'd0);
            chk("final_idle_strobes", d, {30'd0, mr[d], mw[d]}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
